// File: rtl/lfsr_seed_gen.sv
// rtl/lfsr_seed_gen.sv - Galois LFSR random word source with timer/entropy reseed mixing
// and all-zero lock-up recovery, serving one word per valid/ready handshake.
module lfsr_seed_gen #(
   parameter int               WIDTH        = 16,
   parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
   parameter logic [WIDTH-1:0] SEED_DEFAULT = 16'hACE1,
   parameter int               MIX_CYCLES   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             reseed,
   input  logic [WIDTH-1:0] entropy,
   input  logic             rnd_ready,
   output logic             rnd_valid,
   output logic [WIDTH-1:0] rnd_data,
   output logic             reseed_done,
   output logic             seed_fixed
);

   localparam int               CNT_W    = (MIX_CYCLES > 1) ? $clog2(MIX_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIX_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_INIT,
      ST_RUN,
      ST_MIX,
      ST_CHECK
   } state_t;

   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v);
      return (v >> 1) ^ (v[0] ? TAPS : '0);
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lfsr_q, lfsr_d;
   logic [WIDTH-1:0] timer_q;
   logic [WIDTH-1:0] step_s;
   logic [CNT_W-1:0] mix_cnt_q, mix_cnt_d;
   logic             pending_q, pending_d;
   logic             done_d, fixed_d;

   assign step_s   = step(lfsr_q);
   assign rnd_data = lfsr_q;

   always_comb begin
      state_d   = state_q;
      lfsr_d    = lfsr_q;
      mix_cnt_d = mix_cnt_q;
      pending_d = pending_q;
      done_d    = 1'b0;
      fixed_d   = 1'b0;
      case (state_q)
         ST_INIT: begin
            lfsr_d  = SEED_DEFAULT;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            // A handshake and a reseed in the same cycle both land: step first, mix after.
            if (rnd_valid && rnd_ready) begin
               lfsr_d = step_s;
            end
            if (reseed || pending_q) begin
               state_d   = ST_MIX;
               pending_d = 1'b0;
               mix_cnt_d = '0;
            end
         end
         ST_MIX: begin
            lfsr_d = step_s ^ timer_q ^ entropy;
            if (reseed) begin
               mix_cnt_d = '0;
            end else if (mix_cnt_q == CNT_LAST) begin
               state_d = ST_CHECK;
            end else begin
               mix_cnt_d = mix_cnt_q + CNT_W'(1);
            end
         end
         ST_CHECK: begin
            // The all-zero state is the one fixed point of the LFSR; never let RUN see it.
            if (lfsr_q == '0) begin
               lfsr_d  = SEED_DEFAULT;
               fixed_d = 1'b1;
            end
            if (reseed) begin
               pending_d = 1'b1;
            end
            done_d  = 1'b1;
            state_d = ST_RUN;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         lfsr_q      <= SEED_DEFAULT;
         timer_q     <= '0;
         mix_cnt_q   <= '0;
         pending_q   <= 1'b0;
         rnd_valid   <= 1'b0;
         reseed_done <= 1'b0;
         seed_fixed  <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         timer_q     <= timer_q + WIDTH'(1);
         mix_cnt_q   <= mix_cnt_d;
         pending_q   <= pending_d;
         rnd_valid   <= (state_d == ST_RUN);
         reseed_done <= done_d;
         seed_fixed  <= fixed_d;
      end
   end

endmodule

// File: tb/tb_lfsr_seed_gen.sv
// tb/tb_lfsr_seed_gen.sv - directed scoreboard bench for lfsr_seed_gen (default,
// single-mix and 8-bit instances on a shared clock and reset).
module tb_lfsr_seed_gen;

   localparam logic [15:0] SEED = 16'hACE1;
   localparam int          MIXN = 4;

   logic        clk;
   logic        rst_n;

   logic        reseed, rnd_ready, rnd_valid, reseed_done, seed_fixed;
   logic [15:0] entropy, rnd_data;

   logic        m1_reseed, m1_ready, m1_valid, m1_done, m1_fixed;
   logic [15:0] m1_entropy, m1_data;

   logic        w8_reseed, w8_ready, w8_valid, w8_done, w8_fixed;
   logic [7:0]  w8_entropy, w8_data;

   logic [15:0] m_timer;
   logic [15:0] m_s;
   logic [15:0] exp_q[$];
   int          n_vec;
   int          n_err;

   lfsr_seed_gen u_dut (
      .clk(clk), .rst_n(rst_n), .reseed(reseed), .entropy(entropy), .rnd_ready(rnd_ready),
      .rnd_valid(rnd_valid), .rnd_data(rnd_data), .reseed_done(reseed_done), .seed_fixed(seed_fixed)
   );

   lfsr_seed_gen #(.MIX_CYCLES(1)) u_m1 (
      .clk(clk), .rst_n(rst_n), .reseed(m1_reseed), .entropy(m1_entropy), .rnd_ready(m1_ready),
      .rnd_valid(m1_valid), .rnd_data(m1_data), .reseed_done(m1_done), .seed_fixed(m1_fixed)
   );

   lfsr_seed_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED_DEFAULT(8'h01)) u_w8 (
      .clk(clk), .rst_n(rst_n), .reseed(w8_reseed), .entropy(w8_entropy), .rnd_ready(w8_ready),
      .rnd_valid(w8_valid), .rnd_data(w8_data), .reseed_done(w8_done), .seed_fixed(w8_fixed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference free-running timer value in force during the current cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_timer <= '0;
      else        m_timer <= m_timer + 16'd1;
   end

   function automatic logic [15:0] step16(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [7:0] step8(input logic [7:0] v);
      return {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag);
      if (exp_q.size() == 0) begin
         n_vec++;
         n_err++;
         $error("FAIL %s: observed %0h expected <empty scoreboard>", tag, rnd_data);
      end else begin
         chk(tag, rnd_data, exp_q.pop_front());
      end
   endtask

   task automatic release_and_start(input string tag);
      @(posedge clk);
      #1 rst_n = 1'b1;
      m_s = SEED;
      @(negedge clk);
      chk({tag, "_init_valid"}, rnd_valid, 0);
      @(negedge clk);
      chk({tag, "_first_valid"}, rnd_valid, 1);
      exp_q.push_back(m_s);
      chk_word({tag, "_first_word"});
   endtask

   task automatic apply_reset(input string tag);
      rst_n = 1'b0;
      reseed = 0; rnd_ready = 0; entropy = 16'h1234;
      m1_reseed = 0; m1_ready = 0; m1_entropy = 0;
      w8_ready = 0;
      @(posedge clk);
      release_and_start(tag);
   endtask

   // Entered at the negedge of the first MIX cycle; leaves at the negedge of the
   // first RUN cycle after the reseed, with reseed and rnd_ready dropped.
   task automatic mix_phase(input int hold, input bit rs_in_check, input string tag);
      logic fix_exp;
      for (int i = 0; i < MIXN + hold; i++) begin
         if (i > 0) @(negedge clk);
         chk({tag, "_mix_low"}, rnd_valid, 0);
         m_s       = step16(m_s) ^ m_timer ^ entropy;
         reseed    = (i < hold);
         rnd_ready = 1'b1;
      end
      @(negedge clk);
      chk({tag, "_check_low"}, rnd_valid, 0);
      fix_exp = (m_s == 16'h0000);
      if (fix_exp) m_s = SEED;
      reseed = rs_in_check;
      @(negedge clk);
      chk({tag, "_valid_back"}, rnd_valid, 1);
      chk({tag, "_done"}, reseed_done, 1);
      chk({tag, "_fixed"}, seed_fixed, {31'd0, fix_exp});
      exp_q.push_back(m_s);
      chk_word({tag, "_word"});
      reseed    = 1'b0;
      rnd_ready = 1'b0;
   endtask

   task automatic start_reseed(input bit hs, input int hold, input bit rs_in_check, input string tag);
      reseed    = 1'b1;
      rnd_ready = hs;
      if (hs) m_s = step16(m_s);
      @(negedge clk);
      mix_phase(hold, rs_in_check, tag);
   endtask

   task automatic done_cleared(input string tag);
      @(negedge clk);
      chk({tag, "_done_pulse"}, reseed_done, 0);
      chk({tag, "_fixed_pulse"}, seed_fixed, 0);
      chk({tag, "_run_valid"}, rnd_valid, 1);
   endtask

   initial begin
      logic [7:0] w8_m;
      int         first_rep;
      int         zero_seen;

      n_vec = 0;
      n_err = 0;
      rst_n = 1'b1;
      reseed = 0; rnd_ready = 0; entropy = 16'h1234;
      m1_reseed = 0; m1_ready = 0; m1_entropy = 0;
      w8_reseed = 0; w8_ready = 0; w8_entropy = 0;

      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_valid", rnd_valid, 0);
      chk("rst_data", rnd_data, SEED);
      chk("rst_done", reseed_done, 0);
      chk("rst_fixed", seed_fixed, 0);
      release_and_start("boot");

      // Single-cycle accept, then hold with rnd_ready low.
      rnd_ready = 1'b1;
      m_s = step16(m_s);
      exp_q.push_back(m_s);
      @(negedge clk);
      rnd_ready = 1'b0;
      chk("hs_pulse_const", rnd_data, 16'hE270);
      chk_word("hs_pulse");
      exp_q.push_back(m_s);
      @(negedge clk);
      chk_word("hs_hold");
      chk("hs_hold_valid", rnd_valid, 1);

      // Back-to-back stream from the reset seed.
      apply_reset("stream");
      rnd_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         m_s = step16(m_s);
         exp_q.push_back(m_s);
         @(negedge clk);
         chk_word("stream_word");
         chk("stream_valid", rnd_valid, 1);
      end
      rnd_ready = 1'b0;
      @(negedge clk);

      // Plain reseed.
      start_reseed(0, 0, 0, "rs");
      done_cleared("rs");

      // Lock-up recovery on the single-mix instance: force the mix result to zero.
      m1_reseed = 1'b1;
      @(negedge clk);
      m1_reseed  = 1'b0;
      m1_entropy = step16(SEED) ^ m_timer;
      @(negedge clk);
      m1_entropy = 16'h0000;
      chk("lock_check_low", m1_valid, 0);
      @(negedge clk);
      chk("lock_valid", m1_valid, 1);
      chk("lock_data", m1_data, SEED);
      chk("lock_done", m1_done, 1);
      chk("lock_fixed", m1_fixed, 1);
      @(negedge clk);
      chk("lock_done_pulse", m1_done, 0);
      chk("lock_fixed_pulse", m1_fixed, 0);

      // reseed held into the first MIX cycle restarts the mix count.
      start_reseed(0, 1, 0, "rs_mix");
      done_cleared("rs_mix");

      // reseed during CHECK: one RUN cycle with a handshake, then straight back to MIX.
      start_reseed(0, 0, 1, "rs_chk");
      rnd_ready = 1'b1;
      m_s = step16(m_s);
      exp_q.push_back(m_s);
      @(negedge clk);
      chk("rs_chk_run1", rnd_valid, 0);
      chk_word("rs_chk_stepped");
      mix_phase(0, 0, "rs_chk2");
      done_cleared("rs_chk2");

      // Handshake in the same cycle as the reseed request.
      start_reseed(1, 0, 0, "rs_hs");
      done_cleared("rs_hs");

      // Reset asserted during the second MIX cycle.
      reseed = 1'b1;
      @(negedge clk);
      reseed = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rm_valid", rnd_valid, 0);
      chk("rm_data", rnd_data, SEED);
      chk("rm_done", reseed_done, 0);
      chk("rm_fixed", seed_fixed, 0);
      release_and_start("rm");

      // Full period of the 8-bit instance.
      chk("w8_valid", w8_valid, 1);
      chk("w8_seed", w8_data, 8'h01);
      w8_m      = 8'h01;
      first_rep = 0;
      zero_seen = 0;
      w8_ready  = 1'b1;
      for (int i = 1; i <= 255; i++) begin
         w8_m = step8(w8_m);
         @(negedge clk);
         if (w8_data == 8'h00) zero_seen++;
         if (w8_data == 8'h01 && first_rep == 0) first_rep = i;
         chk("w8_seq", w8_data, w8_m);
      end
      w8_ready = 1'b0;
      chk("w8_period", first_rep, 255);
      chk("w8_nonzero", zero_seen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
